// File: rtl/mor1kx_multiclk_ctrl_marocchino_pkg.sv
// ============================================================================
// Module : mor1kx_multiclk_ctrl_marocchino_pkg
// Brief  : Shared state encoding and sizing helpers for the multi-cycle unit
//          controller and its serial divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mor1kx_multiclk_ctrl_marocchino_pkg;

    localparam int         c_STATE_W   = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_MUL    = 2'd1;
    localparam logic [1:0] c_ST_DIV    = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Wide enough to hold MUL_LATENCY-1 for the largest legal latency.
    localparam int         c_MUL_CNT_W = 2;

    function automatic bit mul_latency_legal(input int lat);
        return (lat >= 2) && (lat <= 4);
    endfunction

    function automatic int div_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mor1kx_div_serial_marocchino.sv
// ============================================================================
// Module : mor1kx_div_serial_marocchino
// Brief  : Serial restoring divider, one quotient bit per clock, with signed
//          magnitude conversion on start and sign correction on the output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mor1kx_div_serial_marocchino
    import mor1kx_multiclk_ctrl_marocchino_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             dbz
);

    localparam int c_CNT_W = div_cnt_width(WIDTH);

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_den;
    logic               r_neg;
    logic               r_dbz;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;

    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-a) : a;
    assign w_b_mag = w_b_neg ? (-b) : b;

    // A zero divisor always "fits", so the quotient saturates to all-ones
    // and the sign correction then yields +1 for a negative dividend.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_den};
    assign w_ge    = ~w_diff[WIDTH+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_den <= '0;
            r_neg <= 1'b0;
            r_dbz <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= c_CNT_W'(WIDTH);
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_den <= w_b_mag;
            r_neg <= w_a_neg ^ w_b_neg;
            r_dbz <= (b == '0);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end
    end

    assign done     = (r_cnt == c_CNT_W'(1));
    assign quotient = r_neg ? (-r_quo) : r_quo;
    assign dbz      = r_dbz;

endmodule

`default_nettype wire

// File: rtl/mor1kx_multiclk_ctrl_marocchino.sv
// ============================================================================
// Module : mor1kx_multiclk_ctrl_marocchino
// Brief  : Sequencer for the pipelined multiplier and serial divider; holds
//          the result until write-back. Optional MOR1KX_DIV_ZERO_SHORTCUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mor1kx_multiclk_ctrl_marocchino
    import mor1kx_multiclk_ctrl_marocchino_pkg::*;
#(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter int    MUL_LATENCY          = 2,
    parameter string FEATURE_OVERFLOW     = "NONE",
    parameter string FEATURE_CARRY_FLAG   = "ENABLED"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pipeline_flush_i,
    input  logic                            issue_i,
    input  logic                            op_mul_i,
    input  logic                            op_div_i,
    input  logic                            op_div_signed_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] opa_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] opb_i,
    input  logic                            padv_wb_i,
    output logic                            ready_o,
    output logic                            busy_o,
    output logic                            valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            carry_set_o,
    output logic                            carry_clear_o,
    output logic                            overflow_set_o,
    output logic                            overflow_clear_o
);

    localparam int c_W          = OPTION_OPERAND_WIDTH;
    localparam int c_MUL_STAGES = MUL_LATENCY - 1;
    localparam bit c_CARRY_EN   = (FEATURE_CARRY_FLAG != "NONE");
    localparam bit c_OVF_EN     = (FEATURE_OVERFLOW != "NONE");

    if (!mul_latency_legal(MUL_LATENCY) || (c_W > 63) || (c_W < 2)) begin : g_bad_param
        $error("mor1kx_multiclk_ctrl_marocchino: illegal MUL_LATENCY or operand width");
    end

    logic [c_STATE_W-1:0]   r_state;
    logic [c_STATE_W-1:0]   w_state_nxt;
    logic [c_MUL_CNT_W-1:0] r_mul_cnt;
    logic [c_W-1:0]         r_mul_a;
    logic [c_W-1:0]         r_mul_b;
    logic [c_W-1:0]         r_prod [c_MUL_STAGES];
    logic [c_W-1:0]         w_prod;
    logic                   r_is_div;
    logic                   r_div_signed;
    logic                   r_div_short;

    logic                   w_accept;
    logic                   w_div_short;
    logic                   w_div_start;
    logic                   w_div_done;
    logic                   w_div_dbz;
    logic [c_W-1:0]         w_div_quo;
    logic                   w_div_flag;
    logic                   w_dbz;

`ifdef MOR1KX_DIV_ZERO_SHORTCUT_EN
    assign w_div_short = (opb_i == '0);
`else
    assign w_div_short = 1'b0;
`endif

    assign w_accept    = issue_i & ready_o & (op_mul_i | op_div_i) & ~pipeline_flush_i;
    assign w_div_start = w_accept & op_div_i & ~w_div_short;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (pipeline_flush_i) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_accept) begin
            if (op_div_i) begin
                w_state_nxt = w_div_short ? c_ST_DONE : c_ST_DIV;
            end else begin
                w_state_nxt = c_ST_MUL;
            end
        end else begin
            case (r_state)
                c_ST_MUL:  if (r_mul_cnt == c_MUL_CNT_W'(1)) w_state_nxt = c_ST_DONE;
                c_ST_DIV:  if (w_div_done) w_state_nxt = c_ST_DONE;
                c_ST_DONE: if (padv_wb_i) w_state_nxt = c_ST_IDLE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        ready_o = (r_state == c_ST_IDLE) | ((r_state == c_ST_DONE) & padv_wb_i);
        busy_o  = (r_state != c_ST_IDLE);
        valid_o = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_cnt    <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_is_div     <= 1'b0;
            r_div_signed <= 1'b0;
            r_div_short  <= 1'b0;
        end else if (pipeline_flush_i) begin
            r_mul_cnt <= '0;
        end else if (w_accept) begin
            r_is_div     <= op_div_i;
            r_div_signed <= op_div_signed_i;
            r_div_short  <= op_div_i & w_div_short;
            if (!op_div_i) begin
                r_mul_a   <= opa_i;
                r_mul_b   <= opb_i;
                r_mul_cnt <= c_MUL_CNT_W'(MUL_LATENCY - 1);
            end
        end else if ((r_state == c_ST_MUL) && (r_mul_cnt != '0)) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    // Operands only change on a multiply accept, so the last stage settles
    // and stays put for as long as the result is held.
    assign w_prod = r_mul_a * r_mul_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_MUL_STAGES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_prod[0] <= w_prod;
            for (int i = 1; i < c_MUL_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    mor1kx_div_serial_marocchino #(
        .WIDTH     (c_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .is_signed (op_div_signed_i),
        .a         (opa_i),
        .b         (opb_i),
        .flush     (pipeline_flush_i),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .dbz       (w_div_dbz)
    );

    assign result_o = !valid_o     ? '0 :
                      !r_is_div    ? r_prod[c_MUL_STAGES-1] :
                      r_div_short  ? '0 : w_div_quo;

    assign w_div_flag       = valid_o & r_is_div;
    assign w_dbz            = r_div_short | w_div_dbz;
    assign carry_set_o      = c_CARRY_EN & w_div_flag & ~r_div_signed & w_dbz;
    assign carry_clear_o    = c_CARRY_EN & w_div_flag & ~r_div_signed & ~w_dbz;
    assign overflow_set_o   = c_OVF_EN & w_div_flag & r_div_signed & w_dbz;
    assign overflow_clear_o = c_OVF_EN & w_div_flag & r_div_signed & ~w_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_multiclk_ctrl_marocchino.sv
// ============================================================================
// Module : tb_mor1kx_multiclk_ctrl_marocchino
// Brief  : Self-checking bench for the multi-cycle unit controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mor1kx_multiclk_ctrl_marocchino;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pipeline_flush_i = 1'b0;
    logic         issue_i = 1'b0;
    logic         op_mul_i = 1'b0;
    logic         op_div_i = 1'b0;
    logic         op_div_signed_i = 1'b0;
    logic [W-1:0] opa_i = '0;
    logic [W-1:0] opb_i = '0;
    logic         padv_wb_i = 1'b0;
    logic         ready_o, busy_o, valid_o;
    logic [W-1:0] result_o;
    logic         carry_set_o, carry_clear_o, overflow_set_o, overflow_clear_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mor1kx_multiclk_ctrl_marocchino #(
        .OPTION_OPERAND_WIDTH (W),
        .MUL_LATENCY          (2),
        .FEATURE_OVERFLOW     ("ENABLED"),
        .FEATURE_CARRY_FLAG   ("ENABLED")
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush_i (pipeline_flush_i),
        .issue_i          (issue_i),
        .op_mul_i         (op_mul_i),
        .op_div_i         (op_div_i),
        .op_div_signed_i  (op_div_signed_i),
        .opa_i            (opa_i),
        .opb_i            (opb_i),
        .padv_wb_i        (padv_wb_i),
        .ready_o          (ready_o),
        .busy_o           (busy_o),
        .valid_o          (valid_o),
        .result_o         (result_o),
        .carry_set_o      (carry_set_o),
        .carry_clear_o    (carry_clear_o),
        .overflow_set_o   (overflow_set_o),
        .overflow_clear_o (overflow_clear_o)
    );

    function automatic logic [3:0] flags_now();
        return {carry_set_o, carry_clear_o, overflow_set_o, overflow_clear_o};
    endfunction

    // Reference arithmetic: plain integer maths on the operation definition.
    function automatic logic [31:0] model_q(input bit is_div, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (!is_div) return a * b;
        if (b == 0) begin
`ifdef MOR1KX_DIV_ZERO_SHORTCUT_EN
            return 32'd0;
`else
            if (sgn && a[31]) return 32'd1;
            return 32'hFFFF_FFFF;
`endif
        end
        if (!sgn) return a / b;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return 32'(sa / sb);
    endfunction

    function automatic logic [3:0] model_flags(input bit is_div, input bit sgn, input logic [31:0] b);
        if (!is_div) return 4'b0000;
        if (sgn) return {2'b00, b == 0, b != 0};
        return {b == 0, b != 0, 2'b00};
    endfunction

    function automatic int model_lat(input bit is_div, input logic [31:0] b);
        if (!is_div) return 2;
`ifdef MOR1KX_DIV_ZERO_SHORTCUT_EN
        if (b == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Offers one operation (entered and left at a falling edge) and counts
    // rising edges, starting with the accepting one, until valid_o is seen.
    task automatic run_op(input bit mul, input bit div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b, input bit consume,
                          output int lat, output bit rdy);
        issue_i = 1'b1; op_mul_i = mul; op_div_i = div; op_div_signed_i = sgn;
        opa_i = a; opb_i = b; padv_wb_i = consume;
        #1 rdy = ready_o;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        issue_i = 1'b0; padv_wb_i = 1'b0;
        opa_i = $urandom; opb_i = $urandom;
        while (valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume_result();
        padv_wb_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        padv_wb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (result_o !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_cmp++; if (flags_now() !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", flags_now()); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat; bit rdy;
        run_op(1, 0, 0, 32'h0001_0003, 32'h0000_0005, 0, lat, rdy);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mul_latency: got %0d want 2", lat); end
        n_cmp++; if (result_o !== 32'h0005_000F) begin n_bad++; $display("FAIL mul_result: got %h want 0005000f", result_o); end
        n_cmp++; if (flags_now() !== 4'b0000) begin n_bad++; $display("FAIL mul_flags: got %b want 0000", flags_now()); end
        consume_result();
        n_cmp++; if ({busy_o, valid_o, ready_o} !== 3'b001) begin n_bad++; $display("FAIL mul_consume: got busy/valid/ready %b want 001", {busy_o, valid_o, ready_o}); end
    endtask

    task automatic test_div_directed();
        int lat; bit rdy;
        run_op(0, 1, 1, -32'sd100, 32'd7, 0, lat, rdy);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL sdiv_latency: got %0d want 33", lat); end
        n_cmp++; if (result_o !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL sdiv_result: got %h want fffffff2", result_o); end
        n_cmp++; if (flags_now() !== 4'b0001) begin n_bad++; $display("FAIL sdiv_flags: got %b want 0001", flags_now()); end
        consume_result();
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, rdy);
        n_cmp++; if (result_o !== 32'h8000_0000) begin n_bad++; $display("FAIL minint_result: got %h want 80000000", result_o); end
        n_cmp++; if (flags_now() !== 4'b0001) begin n_bad++; $display("FAIL minint_flags: got %b want 0001", flags_now()); end
        consume_result();
    endtask

    task automatic test_div_zero();
        int lat; bit rdy;
        run_op(0, 1, 0, 32'd10, 32'd0, 0, lat, rdy);
        n_cmp++; if (lat !== model_lat(1, 0)) begin n_bad++; $display("FAIL udbz_latency: got %0d want %0d", lat, model_lat(1, 0)); end
        n_cmp++; if (result_o !== model_q(1, 0, 10, 0)) begin n_bad++; $display("FAIL udbz_result: got %h want %h", result_o, model_q(1, 0, 10, 0)); end
        n_cmp++; if (flags_now() !== 4'b1000) begin n_bad++; $display("FAIL udbz_flags: got %b want 1000", flags_now()); end
        consume_result();
        run_op(0, 1, 1, -32'sd5, 32'd0, 0, lat, rdy);
        n_cmp++; if (result_o !== model_q(1, 1, -32'sd5, 0)) begin n_bad++; $display("FAIL sdbz_neg_result: got %h want %h", result_o, model_q(1, 1, -32'sd5, 0)); end
        n_cmp++; if (flags_now() !== 4'b0010) begin n_bad++; $display("FAIL sdbz_flags: got %b want 0010", flags_now()); end
        consume_result();
        run_op(0, 1, 1, 32'd5, 32'd0, 0, lat, rdy);
        n_cmp++; if (result_o !== model_q(1, 1, 5, 0)) begin n_bad++; $display("FAIL sdbz_pos_result: got %h want %h", result_o, model_q(1, 1, 5, 0)); end
        consume_result();
    endtask

    task automatic test_back_to_back();
        int lat; bit rdy; bit stable;
        run_op(1, 0, 0, 32'd7, 32'd6, 0, lat, rdy);
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || result_o !== 32'd42) stable = 1'b0;
        end
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL hold_stable: got valid %b result %h want 1 / 0000002a", valid_o, result_o); end
        run_op(0, 1, 0, 32'd20, 32'd3, 1, lat, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", rdy); end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        n_cmp++; if (result_o !== 32'd6) begin n_bad++; $display("FAIL b2b_result: got %h want 6", result_o); end
        consume_result();
    endtask

    task automatic test_flush();
        bit seen_valid;
        issue_i = 1'b1; op_mul_i = 1'b0; op_div_i = 1'b1; op_div_signed_i = 1'b0;
        opa_i = 32'd1000; opb_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        issue_i = 1'b0;
        repeat (9) @(negedge clk);
        pipeline_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pipeline_flush_i = 1'b0;
        n_cmp++; if ({ready_o, busy_o, valid_o} !== 3'b100) begin n_bad++; $display("FAIL flush_state: got ready/busy/valid %b want 100", {ready_o, busy_o, valid_o}); end
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o !== 1'b0) seen_valid = 1'b1;
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_valid: got %b want 0", seen_valid); end
        issue_i = 1'b1; op_mul_i = 1'b1; op_div_i = 1'b0; pipeline_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        issue_i = 1'b0; pipeline_flush_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_issue_busy: got %b want 0", busy_o); end
        issue_i = 1'b1; op_mul_i = 1'b0; op_div_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        issue_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL noop_issue_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_random();
        int lat; bit rdy; bit stable;
        bit mul, div, sgn, cons;
        logic [31:0] a, b, exp_q;
        for (int it = 0; it < 24; it++) begin
            int sel = int'($urandom_range(0, 3));
            mul = (sel == 0) || (sel == 3);
            div = (sel != 0);
            sgn = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            cons = 1'($urandom_range(0, 1));
            exp_q = model_q(div, sgn, a, b);
            run_op(mul, div, sgn, a, b, cons, lat, rdy);
            n_cmp++; if (lat !== model_lat(div, b)) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, model_lat(div, b)); end
            n_cmp++; if (result_o !== exp_q) begin n_bad++; $display("FAIL rnd_result[%0d]: a=%h b=%h got %h want %h", it, a, b, result_o, exp_q); end
            n_cmp++; if (flags_now() !== model_flags(div, sgn, b)) begin n_bad++; $display("FAIL rnd_flags[%0d]: got %b want %b", it, flags_now(), model_flags(div, sgn, b)); end
            stable = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (valid_o !== 1'b1 || result_o !== exp_q) stable = 1'b0;
            end
            n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL rnd_hold[%0d]: got valid %b result %h want 1 / %h", it, valid_o, result_o, exp_q); end
            consume_result();
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit rdy;
        issue_i = 1'b1; op_mul_i = 1'b0; op_div_i = 1'b1; op_div_signed_i = 1'b1;
        opa_i = 32'd12345; opb_i = 32'd7;
        @(posedge clk);
        @(negedge clk);
        issue_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready_o, busy_o, valid_o, result_o, flags_now()} !== {3'b100, 32'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy/busy/valid %b result %h flags %b want 100 / 0 / 0000",
                     {ready_o, busy_o, valid_o}, result_o, flags_now());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1, 0, 0, 32'd3, 32'd3, 0, lat, rdy);
        n_cmp++; if (lat !== 2 || result_o !== 32'd9) begin n_bad++; $display("FAIL post_reset_mul: got lat %0d result %h want 2 / 9", lat, result_o); end
        consume_result();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_directed();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mor1kx_multiclk_ctrl_marocchino.md
# mor1kx_multiclk_ctrl_marocchino

Sequencing controller for the MAROCCHINO multi-cycle integer units: a pipelined multiplier and a serial restoring divider. It sits beside the execute ALU and accepts one l.mul*/l.div* operation per issue handshake. It runs the selected unit, holds the result until write-back consumes it, and produces the carry/overflow updates for divide-by-zero. Ownership of the iterative units and their handshake moves out of the 1-clock ALU path.

## Interface
- OPTION_OPERAND_WIDTH, 32, operand/result width W (W ≤ 63).
- MUL_LATENCY, 2, cycles from issue to multiplier result (legal 2..4).
- FEATURE_OVERFLOW, "NONE", "NONE" forces overflow outputs low.
- FEATURE_CARRY_FLAG, "ENABLED", "NONE" forces carry outputs low.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipeline_flush_i  in  1  abort any operation; discard result.
- issue_i  in  1  operation offered this cycle.
- op_mul_i  in  1  operation is multiply.
- op_div_i  in  1  operation is divide.
- op_div_signed_i  in  1  divide is signed (else unsigned).
- opa_i  in  W  operand A / dividend.
- opb_i  in  W  operand B / divisor.
- padv_wb_i  in  1  write-back consumes the held result.
- ready_o  out  1  issue accepted this cycle if issue_i.
- busy_o  out  1  operation in flight or result held.
- valid_o  out  1  result_o and flag outputs valid.
- result_o  out  W  product (low W bits) or quotient.
- carry_set_o / carry_clear_o  out  1 each  unsigned divide: divisor zero / nonzero; qualified by valid_o.
- overflow_set_o / overflow_clear_o  out  1 each  signed divide: divisor zero / nonzero; qualified by valid_o.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: issue_i & ready_o & (op_mul_i | op_div_i) & ~pipeline_flush_i. If op_div_i is set, go to DIV (wins if both set). Else go to MUL. Operands are latched on the same edge.
- Issue with neither op bit: ignored, stay IDLE.
- ready_o = (state==IDLE) | (state==DONE & padv_wb_i). This allows back-to-back issue on the consume cycle.
- MUL: a down-counter is loaded with MUL_LATENCY-1. The product pipeline is operand reg plus MUL_LATENCY-1 product regs. At count 0 → DONE.
- DIV: sign handling and iterations:
  - Signed: operands are converted to magnitude. The result is negated if the operand signs differ.
  - W restoring iterations, 1 per cycle, in the sub-module. Then → DONE.
- Divide by zero, macro absent:
  - unsigned quotient = all-ones;
  - signed quotient = all-ones if opa ≥ 0, 1 if opa < 0.
- Signed 0x80000000 / -1 → 0x80000000, no flag.
- DONE: valid_o=1, result_o and flags held stable. padv_wb_i → IDLE, or directly to MUL/DIV if a new issue is accepted the same cycle.
- padv_wb_i outside DONE: ignored.
- Flush in any state → IDLE next edge; counters cleared; valid_o low from the next cycle. Flush beats issue and consume in the same cycle.
- Flag outputs are 0 when ~valid_o or the operation was a multiply.

## Timing
- Reset values: state IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, all flag outputs 0.
- Outputs are registered or decoded from state only. The exception is ready_o, which depends on padv_wb_i combinationally.
- Issue accepted in cycle N:
  - multiply: valid_o in cycle N+MUL_LATENCY;
  - divide: valid_o in cycle N+W+1 (33 for W=32).
- busy_o = (state != IDLE).
- Reset mid-operation: immediate return to reset values.

## Configuration
- MOR1KX_DIV_ZERO_SHORTCUT_EN defined: zero divisor is detected at issue. The FSM goes straight to DONE, with valid_o in cycle N+1 and quotient forced to 0. Flags are as normal.
- Undefined: zero divisor runs the full W iterations with the quotients above.

## Structure
- Shared package/defines header holds:
  - state encoding localparams (IDLE=0, MUL=1, DIV=2, DONE=3);
  - MUL_LATENCY legal range check;
  - iteration count width (clog2(W+1)).
- One sub-module, mor1kx_div_serial_marocchino, covers the magnitude conversion, W-step restoring core and final negate. Its interface is start, signed, a, b, flush, done, quotient, dbz.
- Multiplier pipeline and FSM are inline.

## Test plan
- Unsigned mul: 0x0001_0003 × 0x0000_0005 at N → valid_o at N+2, result 0x0005_000F; padv_wb_i → IDLE.
- Signed div: -100 / 7 → valid_o at N+33, result 0xFFFF_FFF2, overflow_clear_o=1.
- Unsigned div by zero: 10 / 0 → macro absent: result 0xFFFF_FFFF at N+33, carry_set_o=1. Macro defined: result 0, valid at N+1.
- Back-to-back: DONE with padv_wb_i and issue div 20/3 in the same cycle → accepted; result 6 at 33 cycles later.
- Flush at N+10 of a divide → valid_o never asserts, ready_o=1 next cycle. Flush with simultaneous issue → not accepted.
- Reset asserted in DIV mid-count → all outputs at reset values; a following mul 3×3 → 9.
